// File: rtl/hazard2_soc.sv
// Minimal GPIO-adder SoC: a hardwired sequencer configures A/B as inputs, C as output, then loops C = A + B.
// Optional input synchronizers on A/B are enabled by defining GPIO_INPUT_SYNC_EN.
module hazard2_soc #(
    parameter int WIDTH    = 32,
    parameter int LOOP_GAP = 0
) (
    input  logic             HCLK,
    input  logic             HRESET,
    output logic [WIDTH-1:0] GPIO_OUT_A,
    output logic [WIDTH-1:0] GPIO_OE_A,
    input  logic [WIDTH-1:0] GPIO_IN_A,
    output logic [WIDTH-1:0] GPIO_OUT_B,
    output logic [WIDTH-1:0] GPIO_OE_B,
    input  logic [WIDTH-1:0] GPIO_IN_B,
    output logic [WIDTH-1:0] GPIO_OUT_C,
    output logic [WIDTH-1:0] GPIO_OE_C,
    input  logic [WIDTH-1:0] GPIO_IN_C
);

    localparam logic [2:0] ST_CONFIG  = 3'd0;
    localparam logic [2:0] ST_READ_A  = 3'd1;
    localparam logic [2:0] ST_READ_B  = 3'd2;
    localparam logic [2:0] ST_ADD     = 3'd3;
    localparam logic [2:0] ST_WRITE_C = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    localparam logic [7:0] GAP_LAST = 8'((LOOP_GAP > 0) ? (LOOP_GAP - 1) : 0);

    logic [2:0]       state;
    logic [7:0]       gap_cnt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sample_a;
    logic [WIDTH-1:0] sample_b;

    // Port C pad input is readback-only; the sequencer never looks at it.
    logic unused_in_c;
    assign unused_in_c = ^GPIO_IN_C;

    assign GPIO_OUT_A = '0;
    assign GPIO_OUT_B = '0;

    function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return x + y;
    endfunction

`ifdef GPIO_INPUT_SYNC_EN
    logic [WIDTH-1:0] sync_a_p0, sync_a_p1;
    logic [WIDTH-1:0] sync_b_p0, sync_b_p1;

    // Two-flop synchronizer stages for the asynchronous pad inputs
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync_a_p0 <= '0;
            sync_a_p1 <= '0;
            sync_b_p0 <= '0;
            sync_b_p1 <= '0;
        end else begin
            sync_a_p0 <= GPIO_IN_A;
            sync_a_p1 <= sync_a_p0;
            sync_b_p0 <= GPIO_IN_B;
            sync_b_p1 <= sync_b_p0;
        end
    end

    assign sample_a = sync_a_p1;
    assign sample_b = sync_b_p1;
`else
    assign sample_a = GPIO_IN_A;
    assign sample_b = GPIO_IN_B;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ST_CONFIG;
            gap_cnt    <= '0;
            ra         <= '0;
            rb         <= '0;
            sum        <= '0;
            GPIO_OUT_C <= '0;
            GPIO_OE_A  <= '0;
            GPIO_OE_B  <= '0;
            GPIO_OE_C  <= '0;
        end else begin
            case (state)
                ST_CONFIG: begin
                    GPIO_OE_A <= '0;
                    GPIO_OE_B <= '0;
                    GPIO_OE_C <= '1;
                    state     <= ST_READ_A;
                end
                ST_READ_A: begin
                    ra    <= sample_a;
                    state <= ST_READ_B;
                end
                ST_READ_B: begin
                    rb    <= sample_b;
                    state <= ST_ADD;
                end
                ST_ADD: begin
                    sum   <= add_wrap(ra, rb);
                    state <= ST_WRITE_C;
                end
                ST_WRITE_C: begin
                    GPIO_OUT_C <= sum;
                    gap_cnt    <= '0;
                    state      <= (LOOP_GAP > 0) ? ST_GAP : ST_READ_A;
                end
                ST_GAP: begin
                    // Occupies exactly LOOP_GAP edges before the next READ_A
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_READ_A;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= ST_CONFIG;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard2_soc.sv
// Bench for hazard2_soc: two instances (LOOP_GAP 0 and 5) share inputs and are compared each cycle
// against an edge-indexed model of the firmware loop.
module tb_hazard2_soc;

    localparam int W    = 32;
    localparam int P0   = 4;
    localparam int P5   = 9;
    localparam int HMAX = 4096;
`ifdef GPIO_INPUT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, c_in;

    logic [W-1:0] out_a0, oe_a0, out_b0, oe_b0, out_c0, oe_c0;
    logic [W-1:0] out_a5, oe_a5, out_b5, oe_b5, out_c5, oe_c5;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [W-1:0] hist_a [HMAX];
    logic [W-1:0] hist_b [HMAX];

    always #5 clk = ~clk;

    hazard2_soc #(.WIDTH(W), .LOOP_GAP(0)) dut0 (
        .HCLK(clk), .HRESET(rst),
        .GPIO_OUT_A(out_a0), .GPIO_OE_A(oe_a0), .GPIO_IN_A(a),
        .GPIO_OUT_B(out_b0), .GPIO_OE_B(oe_b0), .GPIO_IN_B(b),
        .GPIO_OUT_C(out_c0), .GPIO_OE_C(oe_c0), .GPIO_IN_C(c_in)
    );

    hazard2_soc #(.WIDTH(W), .LOOP_GAP(5)) dut5 (
        .HCLK(clk), .HRESET(rst),
        .GPIO_OUT_A(out_a5), .GPIO_OE_A(oe_a5), .GPIO_IN_A(a),
        .GPIO_OUT_B(out_b5), .GPIO_OE_B(oe_b5), .GPIO_IN_B(b),
        .GPIO_OUT_C(out_c5), .GPIO_OE_C(oe_c5), .GPIO_IN_C(c_in)
    );

    // Value the sequencer sees at edge e: the pad value SYNC_LAT edges earlier, 0 before it exists.
    function automatic logic [W-1:0] seen(input bit is_b, input int e);
        int idx;
        idx = e - SYNC_LAT;
        if (idx < 1) return '0;
        return is_b ? hist_b[idx] : hist_a[idx];
    endfunction

    // Edge 1 is CONFIG; iteration n reads A at 2+nP, B at 3+nP, writes C at 5+nP.
    function automatic logic [W-1:0] exp_c(input int p, input int k);
        int n;
        if (k < 5) return '0;
        n = (k - 5) / p;
        return seen(1'b0, 2 + n * p) + seen(1'b1, 3 + n * p);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] oe_exp;
        oe_exp = (edge_n >= 1) ? '1 : '0;
        chk("g0_out_c", out_c0, exp_c(P0, edge_n));
        chk("g5_out_c", out_c5, exp_c(P5, edge_n));
        chk("g0_oe_c", oe_c0, oe_exp);
        chk("g5_oe_c", oe_c5, oe_exp);
        chk("g0_ab", out_a0 | oe_a0 | out_b0 | oe_b0, '0);
        chk("g5_ab", out_a5 | oe_a5 | out_b5 | oe_b5, '0);
    endtask

    task automatic tick();
        if (!rst && edge_n < HMAX - 1) begin
            hist_a[edge_n + 1] = a;
            hist_b[edge_n + 1] = b;
        end
        @(posedge clk);
        if (!rst) edge_n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic [W-1:0] va, input logic [W-1:0] vb, input int n);
        a = va;
        b = vb;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset(input int n);
        rst = 1'b1;
        edge_n = 0;
        #1;
        chk("rst_async_out_c0", out_c0, '0);
        chk("rst_async_out_c5", out_c5, '0);
        chk("rst_async_oe_c0", oe_c0, '0);
        chk("rst_async_oe_c5", oe_c5, '0);
        @(negedge clk);
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        a    = '0;
        b    = '0;
        c_in = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        tick();
        chk("cfg_oe_c", oe_c0, 32'hFFFF_FFFF);
        chk("cfg_oe_a", oe_a0, 32'h0);

        hold(32'd37, 32'd58, 30);
        chk("sum95_g0", out_c0, 32'd95);
        chk("sum95_g5", out_c5, 32'd95);

        hold(32'hFFFF_FFFF, 32'd2, 30);
        chk("wrap_g0", out_c0, 32'd1);
        chk("wrap_g5", out_c5, 32'd1);

        hold(32'd10, 32'd20, 30);
        chk("pre_change_g0", out_c0, 32'd30);
        a = 32'd1;
        tick();
        hold(32'd1, 32'd100, 30);
        chk("post_change_g0", out_c0, 32'd101);
        chk("post_change_g5", out_c5, 32'd101);

        hold(32'd37, 32'd58, 30);
        async_reset(3);
        hold(32'd37, 32'd58, 30);
        chk("rst_recover_g0", out_c0, 32'd95);
        chk("rst_recover_g5", out_c5, 32'd95);

        hold(32'd3, 32'd4, 30);
        chk("gap5_sum7", out_c5, 32'd7);

        // Randomized segments with occasional mid-loop resets
        for (int s = 0; s < 60; s++) begin
            c_in = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
                b = $urandom;
                async_reset($urandom_range(1, 3));
            end
            hold($urandom, $urandom, $urandom_range(1, 12));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
